// File: rtl/fs48bit_seq.sv
// Multi-cycle wide subtractor: DIFF = A - B - Bin, one SLICE-bit slice per cycle,
// with a registered borrow chain, status flags and a start/busy/done handshake.
module fs48bit_seq #(
    parameter int WIDTH = 48,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // One slice of subtraction; the extra MSB of the result is the borrow out.
    function automatic logic [SLICE:0] sub_slice(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             bi);
        return {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bi};
    endfunction

    logic [1:0]       state;
    logic [WIDTH-1:0] a_p0, b_p0, acc_p0;
    logic             a_msb_p0, b_msb_p0, brw_p0;
    logic [KW-1:0]    k_p0;
    logic [SLICE:0]   sd;
    logic [WIDTH-1:0] acc_nxt;
    logic             accept;

    // Operands shift right as slices are consumed; results enter the accumulator from the top.
    always_comb begin
        sd      = sub_slice(a_p0[SLICE-1:0], b_p0[SLICE-1:0], brw_p0);
        acc_nxt = (acc_p0 >> SLICE) | (WIDTH'(sd[SLICE-1:0]) << (WIDTH - SLICE));
    end

    assign accept = start && (state != CALC);
    assign busy   = (state == CALC);
    assign done   = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_p0     <= '0;
            b_p0     <= '0;
            acc_p0   <= '0;
            a_msb_p0 <= 1'b0;
            b_msb_p0 <= 1'b0;
            brw_p0   <= 1'b0;
            k_p0     <= '0;
            DIFF     <= '0;
            Bout     <= 1'b0;
            zero     <= 1'b0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (accept) begin
                state    <= CALC;
                a_p0     <= A;
                b_p0     <= B;
                a_msb_p0 <= A[WIDTH-1];
                b_msb_p0 <= B[WIDTH-1];
                brw_p0   <= Bin;
                acc_p0   <= '0;
                k_p0     <= '0;
            end else begin
                case (state)
                    CALC: begin
                        a_p0   <= a_p0 >> SLICE;
                        b_p0   <= b_p0 >> SLICE;
                        acc_p0 <= acc_nxt;
                        brw_p0 <= sd[SLICE];
                        k_p0   <= k_p0 + 1'b1;
                        if (k_p0 == KLAST) begin
                            // All flags publish together with the full result.
                            state <= DONE;
                            DIFF  <= acc_nxt;
                            Bout  <= sd[SLICE];
                            zero  <= (acc_nxt == '0);
                            neg   <= acc_nxt[WIDTH-1];
                            ovf   <= (a_msb_p0 != b_msb_p0) && (acc_nxt[WIDTH-1] != a_msb_p0);
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
